// File: rtl/traffic_controller_if.sv
// Sensor and lamp bundle for the two-road intersection controller.
// The controller takes the slave side; whatever drives the sensors takes the master side.
interface traffic_controller_if;
  logic A;
  logic B;
  logic C;
  logic D;
  logic L_O;
  logic N_S;
  logic L_O_Y;
  logic N_S_Y;

  modport master (output A, B, C, D, input L_O, N_S, L_O_Y, N_S_Y);
  modport slave  (input A, B, C, D, output L_O, N_S, L_O_Y, N_S_Y);
endinterface

// File: rtl/traffic_controller.sv
// Two-phase main/secondary road controller: a Moore FSM with min/max green,
// yellow and all-red phases, driven by synchronized vehicle sensors.
module traffic_controller #(
  parameter int MIN_GREEN_LO = 8,
  parameter int MIN_GREEN_NS = 4,
  parameter int MAX_GREEN_NS = 10,
  parameter int YELLOW       = 2,
  parameter int ALL_RED      = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  traffic_controller_if.slave bus
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_P   = max2(max2(max2(MIN_GREEN_LO, MIN_GREEN_NS),
                                     max2(MAX_GREEN_NS, YELLOW)), ALL_RED);
  localparam int TIMER_W = $clog2(MAX_P + 1);

  localparam logic [TIMER_W-1:0] T_MIN_LO = TIMER_W'(MIN_GREEN_LO - 1);
  localparam logic [TIMER_W-1:0] T_MIN_NS = TIMER_W'(MIN_GREEN_NS - 1);
  localparam logic [TIMER_W-1:0] T_MAX_NS = TIMER_W'(MAX_GREEN_NS - 1);
  localparam logic [TIMER_W-1:0] T_YEL    = TIMER_W'(YELLOW - 1);
  localparam logic [TIMER_W-1:0] T_RED    = TIMER_W'(ALL_RED - 1);

  typedef enum logic [2:0] {
    LO_GRN,
    LO_YEL,
    RED_TO_NS,
    NS_GRN,
    NS_YEL,
    RED_TO_LO
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [TIMER_W-1:0]   r_timer;
  logic [3:0]           r_sync_meta;
  logic [3:0]           r_sync;
  logic                 w_as, w_bs, w_cs, w_ds;
  logic                 w_req;

  // Two-flop synchronizer, bit order {A, B, C, D}. Cleared on reset so a
  // stale sensor value cannot raise a request right after reset release.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_meta <= '0;
      r_sync      <= '0;
    end else begin
      r_sync_meta <= {bus.A, bus.B, bus.C, bus.D};
      r_sync      <= r_sync_meta;
    end
  end

  assign {w_as, w_bs, w_cs, w_ds} = r_sync;
  assign w_req = (w_cs & w_ds & ~(w_as & w_bs)) | ((w_cs | w_ds) & ~w_as & ~w_bs);

  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      LO_GRN:    if (r_timer >= T_MIN_LO && w_req)                 w_next = LO_YEL;
      LO_YEL:    if (r_timer == T_YEL)                              w_next = RED_TO_NS;
      RED_TO_NS: if (r_timer == T_RED)                              w_next = NS_GRN;
      NS_GRN:    if ((r_timer >= T_MIN_NS && !w_req) || r_timer == T_MAX_NS)
                                                                    w_next = NS_YEL;
      NS_YEL:    if (r_timer == T_YEL)                              w_next = RED_TO_LO;
      RED_TO_LO: if (r_timer == T_RED)                              w_next = LO_GRN;
      default:                                                      w_next = LO_GRN;
    endcase
  end

  // Timer restarts on every state entry and saturates while a green is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LO_GRN;
      r_timer <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_timer <= '0;
      end else if (r_timer != '1) begin
        r_timer <= r_timer + TIMER_W'(1);
      end
    end
  end

  assign bus.L_O   = (r_state == LO_GRN);
  assign bus.L_O_Y = (r_state == LO_YEL);
  assign bus.N_S   = (r_state == NS_GRN);
  assign bus.N_S_Y = (r_state == NS_YEL);

endmodule

// File: tb/tb_traffic_controller.sv
// Directed and randomized checks of traffic_controller lamp sequencing,
// using an expectation queue compared against sampled lamp outputs.
module tb_traffic_controller;

  logic clk;
  logic rst_n;

  traffic_controller_if tc_if ();

  traffic_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tc_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] lamps;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Lamp vector order: {L_O, L_O_Y, N_S, N_S_Y}
  logic [3:0] lamps;
  assign lamps = {tc_if.L_O, tc_if.L_O_Y, tc_if.N_S, tc_if.N_S_Y};

  task automatic set_sensors(input logic [3:0] abcd);
    {tc_if.A, tc_if.B, tc_if.C, tc_if.D} = abcd;
  endtask

  task automatic push_exp(input string tag, input logic [3:0] e);
    exp_t x;
    x.tag   = tag;
    x.lamps = e;
    sb_q.push_back(x);
  endtask

  task automatic pop_cmp(input logic [3:0] obs);
    exp_t e;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%b expected=<none>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.lamps)
      else begin
        miscompares++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.lamps);
      end
    end
  endtask

  task automatic check_now(input string tag, input logic [3:0] e);
    push_exp(tag, e);
    pop_cmp(lamps);
  endtask

  task automatic edge_expect(input string tag, input logic [3:0] e, input int n);
    for (int i = 0; i < n; i++) begin
      push_exp(tag, e);
      @(posedge clk);
      #1;
      pop_cmp(lamps);
    end
  endtask

  // Returns at a falling edge with reset released; the next rising edge is edge 1.
  task automatic apply_reset(input logic [3:0] abcd);
    rst_n = 1'b0;
    set_sensors(abcd);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic ns_expected(input logic [3:0] abcd);
    return (abcd == 4'b0010) || (abcd == 4'b0001) || (abcd == 4'b0011) ||
           (abcd == 4'b0111) || (abcd == 4'b1011);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic       seen;
    logic [3:0] rnd;

    rst_n = 1'b0;
    set_sensors(4'b0000);
    #3;
    check_now("reset_lamps", 4'b1000);

    // Phase timing with C only
    apply_reset(4'b0010);
    edge_expect("lo_grn_min",  4'b1000, 7);
    edge_expect("lo_yel",      4'b0100, 2);
    edge_expect("red_to_ns",   4'b0000, 1);
    edge_expect("ns_grn_rise", 4'b0010, 1);
    set_sensors(4'b0000);
    edge_expect("ns_grn_min",  4'b0010, 3);
    edge_expect("ns_yel",      4'b0001, 2);
    edge_expect("red_to_lo",   4'b0000, 1);
    edge_expect("lo_grn_back", 4'b1000, 1);

    // Asynchronous reset in the middle of NS_GRN
    apply_reset(4'b0010);
    repeat (11) @(posedge clk);
    #1;
    check_now("pre_reset_ns", 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_reset", 4'b1000);
    set_sensors(4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    edge_expect("idle_hold", 4'b1000, 50);

    // Max green with C and D held
    apply_reset(4'b0011);
    edge_expect("mx_lo_grn",  4'b1000, 7);
    edge_expect("mx_lo_yel",  4'b0100, 2);
    edge_expect("mx_red",     4'b0000, 1);
    edge_expect("mx_ns_grn",  4'b0010, 10);
    edge_expect("mx_ns_yel",  4'b0001, 2);
    edge_expect("mx_red2",    4'b0000, 1);
    edge_expect("mx_lo_min",  4'b1000, 8);
    edge_expect("mx_reswitch", 4'b0100, 1);

    // Main road priority
    apply_reset(4'b1111);
    edge_expect("main_priority", 4'b1000, 100);

    // Request truth table
    for (int v = 0; v < 16; v++) begin
      apply_reset(4'(v));
      push_exp($sformatf("req_abcd_%04b", 4'(v)), {3'b000, ns_expected(4'(v))});
      seen = 1'b0;
      repeat (30) begin
        @(posedge clk);
        #1;
        seen |= tc_if.N_S;
      end
      pop_cmp({3'b000, seen});
    end

    // One-cycle glitch on C after LO_GRN minimum has elapsed
    apply_reset(4'b0000);
    edge_expect("gl_idle", 4'b1000, 10);
    set_sensors(4'b0010);
    edge_expect("gl_sync1", 4'b1000, 1);
    set_sensors(4'b0000);
    edge_expect("gl_sync2", 4'b1000, 1);
    edge_expect("gl_yel",   4'b0100, 2);
    edge_expect("gl_red",   4'b0000, 1);
    edge_expect("gl_ns",    4'b0010, 1);

    // Randomized sensors: at most one lamp lit at any time
    apply_reset(4'b0000);
    for (int i = 0; i < 10000; i++) begin
      rnd = 4'($urandom);
      set_sensors(rnd);
      push_exp("one_lamp", 4'b0001);
      @(posedge clk);
      #1;
      pop_cmp({3'b000, ($countones(lamps) <= 1)});
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
